// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the sequential adder controller: state encoding,
// requester-id width, nibble width and the nibble-counter sizing helper.
package add_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int ID_W  = 1;
    localparam int NIB_W = 4;

    // A counter over nnib values still needs at least one bit when nnib is 1
    function automatic int cnt_width(input int nnib);
        return (nnib > 1) ? $clog2(nnib) : 1;
    endfunction

endpackage

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder slice with group propagate/generate outputs.
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout,
    output logic       pout,
    output logic       gout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = gout | (pout & cin);

    assign pout = &p;
    assign gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-cycle adder controller: two requesters share one 4-bit CLA slice,
// arbitrated round-robin, each operation walked nibble by nibble from the
// least significant end, result presented on a single valid/ready port.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic [ID_W-1:0]  rsp_id
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int CNT_W = cnt_width(NNIB);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NNIB - 1);

    state_t state;
    state_t next_state;

    logic             rr_ptr;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [ID_W-1:0]  id_q;
    logic             carry_q;
    logic [CNT_W-1:0] k_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [ID_W-1:0]  rsp_id_q;

    logic             is_idle;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             last_nib;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_sum;
    logic             cla_cin;
    logic             cla_cout;
    logic             cla_pout;
    logic             cla_gout;
    logic             unused_cla;
    logic [WIDTH-1:0] res_shift;

    // Readys are also held low during reset so no requester sees a handshake
    // while the controller is being cleared.
    assign is_idle    = (state == IDLE) && rst_n;
    assign grant0     = req0_valid && (!rr_ptr || !req1_valid);
    assign grant1     = req1_valid && ( rr_ptr || !req0_valid);
    assign req0_ready = is_idle && grant0;
    assign req1_ready = is_idle && grant1;
    assign accept     = req0_ready || req1_ready;

    assign last_nib   = (k_q == LAST_K);
    assign nib_a      = a_q[{k_q, 2'b00} +: NIB_W];
    assign nib_b      = b_q[{k_q, 2'b00} +: NIB_W];
    assign cla_cin    = (k_q == '0) ? cin_q : carry_q;

    cla_4b u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (cla_cin),
        .sum  (nib_sum),
        .cout (cla_cout),
        .pout (cla_pout),
        .gout (cla_gout)
    );

    // Group propagate/generate are not needed when rippling nibble by nibble
    assign unused_cla = cla_pout ^ cla_gout;

    // New nibbles enter at the top so after the last step nibble 0 sits at the bottom
    generate
        if (WIDTH > NIB_W) begin : g_shift
            assign res_shift = {nib_sum, res_q[WIDTH-1:NIB_W]};
        end else begin : g_single
            assign res_shift = nib_sum;
        end
    endgenerate

    assign rsp_valid = (state == DONE);
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_id    = rsp_id_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: accept in IDLE, count nibbles in RUN, wait for the consumer in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept)    next_state = RUN;
            RUN:  if (last_nib)  next_state = DONE;
            DONE: if (rsp_ready) next_state = IDLE;
            default:             next_state = IDLE;
        endcase
    end

    // Latch the granted operation and hand priority to the other requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            id_q   <= '0;
            rr_ptr <= 1'b0;
        end else if (accept) begin
            a_q    <= grant1 ? req1_a   : req0_a;
            b_q    <= grant1 ? req1_b   : req0_b;
            cin_q  <= grant1 ? req1_cin : req0_cin;
            id_q   <= ID_W'(grant1);
            rr_ptr <= ~grant1;
        end
    end

    // One nibble per RUN cycle through the shared slice, carry chained in carry_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            k_q     <= '0;
        end else if (state == RUN) begin
            res_q   <= res_shift;
            carry_q <= cla_cout;
            k_q     <= k_q + CNT_W'(1);
        end
    end

    // Publish the finished result; it holds until the next operation completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rsp_id_q <= '0;
        end else if ((state == RUN) && last_nib) begin
            sum_q    <= res_shift;
            cout_q   <= cla_cout;
            ovf_q    <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
            rsp_id_q <= id_q;
        end
    end

endmodule
